// File: rtl/dest_reg_tracker_if.sv
// Decode-side, control, lookup and result signals of the destination-register tracker.
// master = pipeline control / hazard unit side, slave = tracker side.
interface dest_reg_tracker_if;
  logic       freeze;
  logic       flush;
  logic       stall;
  logic       id_valid;
  logic       id_regwrite;
  logic       id_memread;
  logic [4:0] id_rd;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       rs_hit;
  logic [1:0] rs_stage;
  logic       rt_hit;
  logic [1:0] rt_stage;
  logic       load_use;
  logic       busy;

  modport master (
    output freeze, flush, stall, id_valid, id_regwrite, id_memread, id_rd, rs, rt,
    input  rs_hit, rs_stage, rt_hit, rt_stage, load_use, busy
  );

  modport slave (
    input  freeze, flush, stall, id_valid, id_regwrite, id_memread, id_rd, rs, rt,
    output rs_hit, rs_stage, rt_hit, rt_stage, load_use, busy
  );
endinterface

// File: rtl/dest_reg_tracker.sv
// Tracks destination registers of in-flight instructions in a DEPTH-slot shift pipeline
// (slot 0 = EX) and answers zero-latency source-register lookups for hazard/forwarding.
module dest_reg_tracker #(
  parameter int DEPTH = 3
) (
  input logic                clk,
  input logic                reset,
  dest_reg_tracker_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  slot_t slots      [DEPTH];
  slot_t slots_next [DEPTH];
  slot_t cap_entry;
  logic  cap;

  logic       rs_hit, rt_hit, load_use, busy;
  logic [1:0] rs_stage, rt_stage;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    cap        = bus.id_valid & bus.id_regwrite & (bus.id_rd != 5'd0);
    cap_entry  = '{valid: cap, rd: (cap ? bus.id_rd : 5'd0), is_load: bus.id_memread & cap};
    slots_next = slots;
    if (!bus.freeze) begin
      for (int k = 1; k < DEPTH; k++) slots_next[k] = slots[k-1];
      // Flush kills the wrong-path EX/MEM work; the old MEM entry has already moved on.
      if (bus.flush) begin
        slots_next[0] = '0;
        slots_next[1] = '0;
      end else if (bus.stall) begin
        slots_next[0] = '0;
      end else begin
        slots_next[0] = cap_entry;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every slot samples pre-edge values.
  // NOTE: the slot array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
    end else begin
      slots <= slots_next;
    end
  end

  // Scan oldest-to-youngest so the last hit written is the youngest producer.
  always_comb begin
    rs_hit   = 1'b0;
    rs_stage = 2'd0;
    rt_hit   = 1'b0;
    rt_stage = 2'd0;
    busy     = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].rd == bus.rs) && (bus.rs != 5'd0)) begin
        rs_hit   = 1'b1;
        rs_stage = 2'(k);
      end
      if (slots[k].valid && (slots[k].rd == bus.rt) && (bus.rt != 5'd0)) begin
        rt_hit   = 1'b1;
        rt_stage = 2'(k);
      end
      busy = busy | slots[k].valid;
    end
    load_use = slots[0].valid & slots[0].is_load &
               (((slots[0].rd == bus.rs) && (bus.rs != 5'd0)) ||
                ((slots[0].rd == bus.rt) && (bus.rt != 5'd0)));
  end

  assign bus.rs_hit   = rs_hit;
  assign bus.rs_stage = rs_stage;
  assign bus.rt_hit   = rt_hit;
  assign bus.rt_stage = rt_stage;
  assign bus.load_use = load_use;
  assign bus.busy     = busy;

endmodule

// File: doc/dest_reg_tracker.md
Name: dest_reg_tracker

Overview:
- Writer-side companion to the register-index comparators: records destination registers of in-flight instructions as they move through the pipeline and answers source-register lookups.
- Sits between decode and the hazard/forwarding logic, and provides the hit, stage and load-use signals they need.
- Implements a DEPTH-slot shift pipeline of (valid, rd, is_load) entries plus combinational match logic.

Parameters:
- DEPTH, 3, number of tracked stages after decode (slot 0 = EX, 1 = MEM, 2 = WB); legal range 2..4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all slots
- freeze  input  1  hold every slot unchanged this cycle
- flush  input  1  invalidate slots 0 and 1 at next edge (wrong-path kill)
- stall  input  1  insert bubble into slot 0; older slots still advance
- id_valid  input  1  decode holds a real instruction
- id_regwrite  input  1  decode instruction writes a register
- id_memread  input  1  decode instruction is a load
- id_rd  input  5  decode destination register index
- rs  input  5  source register A to look up
- rt  input  5  source register B to look up
- rs_hit  output  1  rs matches a valid in-flight destination
- rs_stage  output  2  slot index of youngest match for rs; 0 when no hit
- rt_hit  output  1  as rs_hit, for rt
- rt_stage  output  2  as rs_stage, for rt
- load_use  output  1  rs or rt matches slot 0 and slot 0 is a load
- busy  output  1  any slot valid

Behaviour:
- One clock domain; reset is asynchronous and active-high. While reset is high, all slots are valid=0, rd=0, is_load=0, so every output is 0.
- Slot capture is `cap = id_valid & id_regwrite & (id_rd != 0)`. Register 0 is never tracked. is_load is captured as `id_memread & cap`.
- Edge update, in priority order:
  - reset: clear all slots.
  - freeze: all slots hold. flush and stall are ignored that cycle.
  - flush: slot0 and slot1 become invalid. Slots k >= 2 take slot k-1 as normal, with the old slot1 content shifted into slot 2 before the kill. Decode input is discarded.
  - stall: slot0 takes a bubble (valid=0); slot k takes slot k-1 for k >= 1.
  - normal: slot0 takes the capture; slot k takes slot k-1. The oldest entry retires off the end.
- Lookup is purely combinational on current slot contents, with zero latency. It does not see the instruction currently in decode.
- Match rule for slot k: `valid_k & (rd_k == src) & (src != 0)`.
- rs_hit / rt_hit are the OR of the per-slot matches.
- rs_stage / rt_stage give the lowest matching index, so the youngest producer wins when several slots share an rd.
- load_use is `slot0.valid & slot0.is_load & (rs matches slot0 | rt matches slot0)`.
- busy is the OR of all valid bits.
- Simultaneous stall+flush: flush wins. Slot 0 is invalid either way; slot 1 is also killed.
- Entry lifetime: with no freeze, an entry is visible for exactly DEPTH cycles after the capture edge.
- Reset asserted mid-operation clears slots immediately, without waiting for a clock edge.
- Deassertion takes effect at the next rising edge.

Test Plan:
- Reset check: assert reset with slots full of rd=5. Outputs 0 asynchronously, before any clk edge. After release, with rs=5, rs_hit=0 and busy=0.
- Basic flow: issue rd=7 (regwrite=1) for one cycle, then bubbles, with rs=7.
  - Next 3 cycles: rs_hit=1 with rs_stage=0, 1, 2.
  - 4th cycle: rs_hit=0 and busy=0.
- Youngest wins and r0: issue rd=9, then rd=9 again, then rd=0.
  - With rt=9 after the third edge: rt_hit=1, rt_stage=1.
  - rs=0: rs_hit=0 always.
  - Slot 0 holds no valid entry.
- Load-use: issue a load with rd=4, set rs=4 and rt=3.
  - Next cycle: load_use=1, rs_stage=0.
  - Assert stall one cycle: slot0 becomes a bubble, the entry moves to slot 1, load_use=0, rs_stage=1.
- Flush: fill slots with rd=1, 2, 3 (slot0=3).
  - Assert flush with decode issuing rd=8.
  - Next cycle only slot 2 is valid, holding rd=2 (previous slot 1 shifted before kill). Lookup of 2 gives hit with stage 2; lookups of 3, 8 and 1 give no hit.
- Freeze priority: with slots holding rd=1, 2, 3, assert freeze+flush+stall together for 2 cycles. Contents stay unchanged: lookup of 3 gives stage 0, lookup of 1 gives stage 2.
